// File: rtl/cpu_core_mc.sv
// cpu_core_mc: multi-cycle Beta-style CPU; ALU/branch 4 cycles, LD/ST 5, +1 per IM/DM wait cycle; requests hold until ack.
// Optional macro CPU_MUL_EN enables MUL/MULC (fn 2); otherwise fn 2 is an illegal opcode.
module cpu_core_mc #(
    parameter int               DATA_W   = 32,
    parameter int               ADDR_W   = 32,
    parameter int               REG_CNT  = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_run,
    output logic              o_halt,
    output logic              o_err,
    output logic [6:0]        o_phase,
    output logic              o_im_req,
    output logic [ADDR_W-1:0] o_im_addr,
    input  logic [31:0]       i_im_rdata,
    input  logic              i_im_ack,
    output logic              o_dm_req,
    output logic              o_dm_we,
    output logic [ADDR_W-1:0] o_dm_addr,
    output logic [DATA_W-1:0] o_dm_wdata,
    input  logic [DATA_W-1:0] i_dm_rdata,
    input  logic              i_dm_ack,
    input  logic [4:0]        i_dbg_rf_addr,
    output logic [DATA_W-1:0] o_dbg_rf_rdata
);
    localparam int RI_W = $clog2(REG_CNT);
    localparam int SH_W = $clog2(DATA_W);
    localparam logic [RI_W-1:0] ZERO_IDX = RI_W'(REG_CNT - 1);

    localparam logic [5:0] OP_HALT = 6'h00;
    localparam logic [5:0] OP_LD   = 6'h18;
    localparam logic [5:0] OP_ST   = 6'h19;
    localparam logic [5:0] OP_JMP  = 6'h1B;
    localparam logic [5:0] OP_BEQ  = 6'h1C;
    localparam logic [5:0] OP_BNE  = 6'h1D;

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALTED
    } state_t;

    state_t r_state, w_next;

    logic [ADDR_W-1:0] r_pc, r_pc_nxt, r_dm_addr;
    logic [31:0]       r_ir;
    logic [DATA_W-1:0] r_a, r_b, r_c, r_res, r_dm_wdata;
    logic              r_dm_we, r_err;
    logic [DATA_W-1:0] r_rf [REG_CNT];

    logic [5:0]        w_op;
    logic [RI_W-1:0]   w_rc, w_ra, w_rb, w_dbg_idx;
    logic [DATA_W-1:0] w_sxt, w_ra_val, w_rb_val, w_rc_val, w_alu, w_ea, w_link;
    logic [ADDR_W-1:0] w_pc4, w_br_tgt;
    logic [SH_W-1:0]   w_sh;
    logic              w_fn_ok, w_legal;

    assign w_op      = r_ir[31:26];
    assign w_rc      = r_ir[21 +: RI_W];
    assign w_ra      = r_ir[16 +: RI_W];
    assign w_rb      = r_ir[11 +: RI_W];
    assign w_sxt     = DATA_W'($signed(r_ir[15:0]));
    assign w_dbg_idx = i_dbg_rf_addr[RI_W-1:0];

    // The top register index is hardwired to zero on every read path.
    assign w_ra_val       = (w_ra == ZERO_IDX) ? '0 : r_rf[w_ra];
    assign w_rb_val       = (w_rb == ZERO_IDX) ? '0 : r_rf[w_rb];
    assign w_rc_val       = (w_rc == ZERO_IDX) ? '0 : r_rf[w_rc];
    assign o_dbg_rf_rdata = (w_dbg_idx == ZERO_IDX) ? '0 : r_rf[w_dbg_idx];

    assign w_sh     = r_b[SH_W-1:0];
    assign w_ea     = r_a + r_b;
    assign w_pc4    = r_pc + ADDR_W'(4);
    assign w_br_tgt = w_pc4 + ADDR_W'(r_b << 2);
    assign w_link   = DATA_W'(w_pc4);

    always_comb begin
        w_fn_ok = 1'b0;
        case (w_op[3:0])
            4'h0, 4'h1, 4'h4, 4'h5, 4'h6, 4'h8, 4'h9, 4'hA, 4'hC, 4'hD, 4'hE: w_fn_ok = 1'b1;
`ifdef CPU_MUL_EN
            4'h2: w_fn_ok = 1'b1;
`else
            4'h2: w_fn_ok = 1'b0;
`endif
            default: w_fn_ok = 1'b0;
        endcase
        case (w_op)
            OP_HALT, OP_LD, OP_ST, OP_JMP, OP_BEQ, OP_BNE: w_legal = 1'b1;
            default: w_legal = w_op[5] & w_fn_ok;
        endcase
    end

    always_comb begin
        w_alu = '0;
        case (w_op[3:0])
            4'h0: w_alu = r_a + r_b;
            4'h1: w_alu = r_a - r_b;
`ifdef CPU_MUL_EN
            4'h2: w_alu = r_a * r_b;
`endif
            4'h4: w_alu = DATA_W'(r_a == r_b);
            4'h5: w_alu = DATA_W'($signed(r_a) < $signed(r_b));
            4'h6: w_alu = DATA_W'($signed(r_a) <= $signed(r_b));
            4'h8: w_alu = r_a & r_b;
            4'h9: w_alu = r_a | r_b;
            4'hA: w_alu = r_a ^ r_b;
            4'hC: w_alu = r_a << w_sh;
            4'hD: w_alu = r_a >> w_sh;
            4'hE: w_alu = DATA_W'($signed(r_a) >>> w_sh);
            default: w_alu = '0;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next   = r_state;
        o_phase  = '0;
        o_im_req = 1'b0;
        o_dm_req = 1'b0;
        case (r_state)
            S_IDLE: begin
                o_phase[6] = 1'b1;
                if (i_run) w_next = S_FETCH;
            end
            S_FETCH: begin
                o_phase[0] = 1'b1;
                o_im_req   = 1'b1;
                if (i_im_ack) w_next = S_DECODE;
            end
            S_DECODE: begin
                o_phase[1] = 1'b1;
                w_next     = (!w_legal || w_op == OP_HALT) ? S_HALTED : S_EXEC;
            end
            S_EXEC: begin
                o_phase[2] = 1'b1;
                w_next     = (w_op == OP_LD || w_op == OP_ST) ? S_MEM : S_WB;
            end
            S_MEM: begin
                o_phase[3] = 1'b1;
                o_dm_req   = 1'b1;
                if (i_dm_ack) w_next = S_WB;
            end
            S_WB: begin
                o_phase[4] = 1'b1;
                w_next     = i_run ? S_FETCH : S_IDLE;
            end
            S_HALTED: o_phase[5] = 1'b1;
            default:  w_next = S_IDLE;
        endcase
    end

    assign o_halt     = (r_state == S_HALTED);
    assign o_err      = r_err;
    assign o_im_addr  = r_pc;
    assign o_dm_we    = o_dm_req & r_dm_we;
    assign o_dm_addr  = r_dm_addr;
    assign o_dm_wdata = r_dm_wdata;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_pc       <= RESET_PC;
            r_pc_nxt   <= RESET_PC;
            r_ir       <= '0;
            r_a        <= '0;
            r_b        <= '0;
            r_c        <= '0;
            r_res      <= '0;
            r_dm_addr  <= '0;
            r_dm_wdata <= '0;
            r_dm_we    <= 1'b0;
            r_err      <= 1'b0;
            for (int i = 0; i < REG_CNT; i++) r_rf[i] <= '0;
        end else begin
            case (r_state)
                S_FETCH: if (i_im_ack) r_ir <= i_im_rdata;
                S_DECODE: begin
                    r_a <= w_ra_val;
                    r_b <= (w_op[5:4] == 2'b10) ? w_rb_val : w_sxt;
                    r_c <= w_rc_val;
                    if (!w_legal) r_err <= 1'b1;
                end
                S_EXEC: begin
                    r_pc_nxt <= w_pc4;
                    r_res    <= w_alu;
                    if (w_op == OP_LD || w_op == OP_ST) begin
                        r_dm_addr  <= ADDR_W'(w_ea);
                        r_dm_wdata <= r_c;
                        r_dm_we    <= (w_op == OP_ST);
                    end
                    if (w_op == OP_JMP) begin
                        r_res    <= w_link;
                        r_pc_nxt <= ADDR_W'(r_a) & ~ADDR_W'(3);
                    end
                    if (w_op == OP_BEQ || w_op == OP_BNE) begin
                        r_res <= w_link;
                        if ((r_a == '0) == (w_op == OP_BEQ)) r_pc_nxt <= w_br_tgt;
                    end
                end
                S_MEM: if (i_dm_ack && !r_dm_we) r_res <= i_dm_rdata;
                S_WB: begin
                    r_pc <= r_pc_nxt;
                    if (w_op != OP_ST && w_rc != ZERO_IDX) r_rf[w_rc] <= r_res;
                end
                default: ;
            endcase
        end
    end
endmodule
